uart_periph: RTL and testbench

Memory-mapped UART peripheral on the picorv32 native bus, decoded by the top-level chip-select logic alongside ROM, RAM, char RAM and LED. It drives `ftdi_rxd` and samples `ftdi_txd`, giving firmware a byte-wide serial console.
- TX side: a FIFO feeding a 8N1 serialiser.
- RX side: a 2-FF synchroniser, a mid-bit sampling deserialiser and a receive buffer.
- Own one-cycle `ready` handshake, matching the other bus slaves.

---
 rtl/uart_periph.sv | 364 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_periph.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TX FIFO + serialiser, synchronised mid-bit RX deserialiser.
// Define UART_RX_FIFO_EN for an RX_DEPTH receive FIFO; otherwise a single holding register.
module uart_periph #(
    parameter int CLK_HZ   = 25000000,
    parameter int BAUD     = 115200,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic [3:0]  wstrb,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    input  logic        rxd,
    output logic        txd
);

    localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD - 1);
    localparam int          TAW     = $clog2(TX_DEPTH);
    localparam logic [TAW:0] TX_CAP = (TAW + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    logic        ready_r;
    logic [31:0] rdata_r;
    logic [31:0] rdata_s;
    logic [15:0] div_r;
    logic        access_s;
    logic        rd_pop_s;
    logic        clr_ovr_s;
    logic        clr_fe_s;
    logic        overrun_r;
    logic        frame_err_r;
    logic        unused_s;

    logic [7:0]   tx_mem_r [TX_DEPTH];
    logic [TAW:0] tx_wr_ptr_r;
    logic [TAW:0] tx_rd_ptr_r;
    logic [TAW:0] tx_count_s;
    logic         tx_full_s;
    logic         tx_empty_s;
    logic         tx_push_s;
    logic         tx_pop_s;
    logic         tx_wr_s;
    logic         tx_rd_s;
    logic         tx_have_s;
    logic [7:0]   tx_next_s;
    logic         tx_busy_s;

    uart_state_t tx_state_r, tx_state_s;
    logic [15:0] tx_cnt_r, tx_cnt_s;
    logic [2:0]  tx_bit_r, tx_bit_s;
    logic [7:0]  tx_shift_r, tx_shift_s;
    logic        txd_r, txd_s;

    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_prev_r;
    uart_state_t rx_state_r, rx_state_s;
    logic [15:0] rx_cnt_r, rx_cnt_s;
    logic [2:0]  rx_bit_r, rx_bit_s;
    logic [7:0]  rx_shift_r, rx_shift_s;
    logic        rx_deliver_s;
    logic        rx_ferr_s;
    logic        rx_avail_s;
    logic [7:0]  rx_head_s;
    logic        rx_ovr_set_s;

    assign access_s  = ready_r && cs;
    assign tx_push_s = access_s && (addr == 2'd0) && wstrb[0] && !tx_full_s;
    // Only a DATA read that actually returned a byte (bit 31) may pop.
    assign rd_pop_s  = access_s && (addr == 2'd0) && (wstrb == 4'd0) && rdata_r[31];
    assign clr_ovr_s = access_s && (addr == 2'd1) && wstrb[0] && wdata[3];
    assign clr_fe_s  = access_s && (addr == 2'd1) && wstrb[0] && wdata[5];
    assign unused_s  = ^{wdata[31:16], 1'(RX_DEPTH)};

    assign tx_count_s = tx_wr_ptr_r - tx_rd_ptr_r;
    assign tx_full_s  = (tx_count_s == TX_CAP);
    assign tx_empty_s = (tx_count_s == '0);
    // An idle serialiser takes a byte straight off the bus, so the FIFO is bypassed.
    assign tx_have_s  = !tx_empty_s || tx_push_s;
    assign tx_next_s  = tx_empty_s ? wdata[7:0] : tx_mem_r[tx_rd_ptr_r[TAW-1:0]];
    assign tx_wr_s    = tx_push_s && !(tx_pop_s && tx_empty_s);
    assign tx_rd_s    = tx_pop_s && !tx_empty_s;
    assign tx_busy_s  = (tx_state_r != ST_IDLE);

    // Bus read mux.
    always_comb begin
        rdata_s = 32'd0;
        case (addr)
            2'd0: begin
                if (rx_avail_s) rdata_s = {1'b1, 23'd0, rx_head_s};
                else            rdata_s = 32'd0;
            end
            2'd1: rdata_s = {26'd0, frame_err_r, tx_busy_s, overrun_r, rx_avail_s, tx_empty_s, tx_full_s};
            2'd2: rdata_s = {16'd0, div_r};
            default: rdata_s = 32'd0;
        endcase
    end

    // Handshake, read data, divisor and sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r     <= 1'b0;
            rdata_r     <= 32'd0;
            div_r       <= DIV_RST;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            ready_r <= !ready_r && cs;
            rdata_r <= (!ready_r && cs) ? rdata_s : 32'd0;
            if (access_s && (addr == 2'd2) && wstrb[0]) div_r[7:0]  <= wdata[7:0];
            if (access_s && (addr == 2'd2) && wstrb[1]) div_r[15:8] <= wdata[15:8];
            if (rx_ovr_set_s)   overrun_r <= 1'b1;
            else if (clr_ovr_s) overrun_r <= 1'b0;
            if (rx_ferr_s)      frame_err_r <= 1'b1;
            else if (clr_fe_s)  frame_err_r <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr_r <= '0;
            tx_rd_ptr_r <= '0;
        end else begin
            if (tx_wr_s) tx_wr_ptr_r <= tx_wr_ptr_r + 1'b1;
            if (tx_rd_s) tx_rd_ptr_r <= tx_rd_ptr_r + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_wr_s) tx_mem_r[tx_wr_ptr_r[TAW-1:0]] <= wdata[7:0];
    end

    // TX serialiser next state; txd is registered alongside the state.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        txd_s      = txd_r;
        tx_pop_s   = 1'b0;
        case (tx_state_r)
            ST_IDLE: begin
                if (tx_have_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_s = tx_next_s;
                    tx_cnt_s   = div_r;
                    tx_state_s = ST_START;
                    txd_s      = 1'b0;
                end else begin
                    txd_s = 1'b1;
                end
            end
            ST_START: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_cnt_s   = div_r;
                    tx_bit_s   = 3'd0;
                    tx_state_s = ST_DATA;
                    txd_s      = tx_shift_r[0];
                end else begin
                    tx_cnt_s = tx_cnt_r - 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_cnt_s = div_r;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_s = ST_STOP;
                        txd_s      = 1'b1;
                    end else begin
                        tx_bit_s   = tx_bit_r + 3'd1;
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                        txd_s      = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r - 16'd1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_r == 16'd0) begin
                    if (tx_have_s) begin
                        tx_pop_s   = 1'b1;
                        tx_shift_s = tx_next_s;
                        tx_cnt_s   = div_r;
                        tx_state_s = ST_START;
                        txd_s      = 1'b0;
                    end else begin
                        tx_state_s = ST_IDLE;
                        txd_s      = 1'b1;
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r - 16'd1;
                end
            end
            default: begin
                tx_state_s = ST_IDLE;
                txd_s      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            txd_r      <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            txd_r      <= txd_s;
        end
    end

    // RX synchroniser plus previous-sample for start-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rxd;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX deserialiser: half-bit wait to the start-bit centre, then whole bits.
    always_comb begin
        rx_state_s   = rx_state_r;
        rx_cnt_s     = rx_cnt_r;
        rx_bit_s     = rx_bit_r;
        rx_shift_s   = rx_shift_r;
        rx_deliver_s = 1'b0;
        rx_ferr_s    = 1'b0;
        case (rx_state_r)
            ST_IDLE: begin
                if (rx_prev_r && !rx_sync_r) begin
                    rx_cnt_s   = div_r >> 1;
                    rx_state_s = ST_START;
                end else begin
                    rx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_r == 16'd0) begin
                    if (!rx_sync_r) begin
                        rx_cnt_s   = div_r;
                        rx_bit_s   = 3'd0;
                        rx_state_s = ST_DATA;
                    end else begin
                        rx_state_s = ST_IDLE;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r - 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_r == 16'd0) begin
                    rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
                    rx_cnt_s   = div_r;
                    if (rx_bit_r == 3'd7) rx_state_s = ST_STOP;
                    else                  rx_bit_s   = rx_bit_r + 3'd1;
                end else begin
                    rx_cnt_s = rx_cnt_r - 16'd1;
                end
            end
            ST_STOP: begin
                if (rx_cnt_r == 16'd0) begin
                    rx_state_s = ST_IDLE;
                    if (rx_sync_r) rx_deliver_s = 1'b1;
                    else           rx_ferr_s    = 1'b1;
                end else begin
                    rx_cnt_s = rx_cnt_r - 16'd1;
                end
            end
            default: rx_state_s = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int           RAW    = $clog2(RX_DEPTH);
    localparam logic [RAW:0] RX_CAP = (RAW + 1)'(RX_DEPTH);

    logic [7:0]   rx_mem_r [RX_DEPTH];
    logic [RAW:0] rx_wr_ptr_r;
    logic [RAW:0] rx_rd_ptr_r;
    logic [RAW:0] rx_count_s;
    logic         rx_full_s;
    logic         rx_wr_s;

    assign rx_count_s   = rx_wr_ptr_r - rx_rd_ptr_r;
    assign rx_full_s    = (rx_count_s == RX_CAP);
    assign rx_avail_s   = (rx_count_s != '0);
    assign rx_head_s    = rx_mem_r[rx_rd_ptr_r[RAW-1:0]];
    assign rx_wr_s      = rx_deliver_s && (!rx_full_s || rd_pop_s);
    assign rx_ovr_set_s = rx_deliver_s && rx_full_s && !rd_pop_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr_r <= '0;
            rx_rd_ptr_r <= '0;
        end else begin
            if (rx_wr_s)  rx_wr_ptr_r <= rx_wr_ptr_r + 1'b1;
            if (rd_pop_s) rx_rd_ptr_r <= rx_rd_ptr_r + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_wr_s) rx_mem_r[rx_wr_ptr_r[RAW-1:0]] <= rx_shift_r;
    end
`else
    logic [7:0] rx_hold_r;
    logic       rx_valid_r;

    assign rx_avail_s   = rx_valid_r;
    assign rx_head_s    = rx_hold_r;
    assign rx_ovr_set_s = rx_deliver_s && rx_valid_r && !rd_pop_s;

    // Single holding register: a byte arriving while full is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hold_r  <= 8'd0;
            rx_valid_r <= 1'b0;
        end else if (rx_deliver_s && (!rx_valid_r || rd_pop_s)) begin
            rx_hold_r  <= rx_shift_r;
            rx_valid_r <= 1'b1;
        end else if (rd_pop_s) begin
            rx_valid_r <= 1'b0;
        end
    end
`endif

    assign ready = ready_r;
    assign rdata = rdata_r;
    assign txd   = txd_r;

endmodule

// File: tb/tb_uart_periph.sv
// Directed/randomised bench for uart_periph against a frame-level reference model.
module tb_uart_periph;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic [3:0]  wstrb = 4'd0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic        rxd;
    logic        txd;
    logic        rxd_drv = 1'b1;
    logic        loop_en = 1'b0;

    int tests = 0;
    int fails = 0;

`ifdef UART_RX_FIFO_EN
    localparam int RX_CAP = 16;
`else
    localparam int RX_CAP = 1;
`endif
    localparam int TX_CAP = 16;

    logic       log_en = 1'b0;
    logic       txlog[$];
    logic [7:0] exp_q[$];
    logic [7:0] rxq[$];

    assign rxd = loop_en ? txd : rxd_drv;

    always #5 clk = ~clk;

    always @(negedge clk) if (log_en) txlog.push_back(txd);

    uart_periph #(
        .CLK_HZ(25000000), .BAUD(115200), .TX_DEPTH(16), .RX_DEPTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wstrb(wstrb), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .rxd(rxd), .txd(txd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] q);
        int n;
        cs = 1'b1; addr = a; wstrb = s; wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < 8);
        check("bus_ready", 32'(ready), 32'd1);
        q = rdata;
        @(posedge clk);
        #1;
        cs = 1'b0; wstrb = 4'd0; wdata = 32'd0;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] q;
        bus(a, s, d, q);
    endtask

    task automatic reg_read(input logic [1:0] a, input string tag, input logic [31:0] exp);
        logic [31:0] q;
        bus(a, 4'd0, 32'd0, q);
        check(tag, q, exp);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      rxd_drv = 1'b0;
            else if (i == 9) rxd_drv = stop;
            else             rxd_drv = b[i-1];
            tick(d + 1);
        end
        rxd_drv = 1'b1;
    endtask

    // Compare the logged txd waveform with ideal back-to-back 8N1 frames of exp_q.
    task automatic check_tx(input int d, input int start_exp);
        int idx;
        int p;
        int per;
        int errs;
        logic [7:0] ob;
        logic idle;
        per = d + 1;
        idx = -1;
        for (int i = 0; i < txlog.size(); i++) begin
            if (txlog[i] == 1'b0) begin
                idx = i;
                break;
            end
        end
        check("tx_start_idx", 32'(idx), 32'(start_exp));
        if (idx < 0) idx = 0;
        p = idx;
        foreach (exp_q[f]) begin
            errs = 0;
            ob = 8'd0;
            for (int k = 0; k < 10 * per; k++) begin
                int bp;
                logic e;
                bp = k / per;
                if (bp == 0)      e = 1'b0;
                else if (bp == 9) e = 1'b1;
                else              e = exp_q[f][bp-1];
                if (p + k >= txlog.size())   errs++;
                else if (txlog[p+k] !== e)   errs++;
                if (bp >= 1 && bp <= 8 && (k % per) == per / 2 && p + k < txlog.size())
                    ob[bp-1] = txlog[p+k];
            end
            check("tx_byte", 32'(ob), 32'(exp_q[f]));
            check("tx_bit_errs", 32'(errs), 32'd0);
            p += 10 * per;
        end
        if (p < txlog.size()) idle = txlog[p];
        else                  idle = 1'b0;
        check("tx_idle_after", 32'(idle), 32'd1);
    endtask

    initial begin
        logic [7:0]  b;
        logic [15:0] div_m;
        logic [31:0] w;
        logic [3:0]  s;
        int          d;
        int          n;
        int          zeros;

        // Reset state
        tick(3);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        tick(2);
        reg_read(2'd1, "rst_status", 32'h02);
        reg_read(2'd2, "rst_div", 32'd216);
        reg_read(2'd0, "data_empty", 32'd0);
        reg_write(2'd3, 4'hF, 32'hFFFF_FFFF);
        reg_read(2'd3, "reg3", 32'd0);

        // Divisor byte strobes
        div_m = 16'd216;
        for (int it = 0; it < 4; it++) begin
            w = $urandom;
            s = 4'($urandom_range(1, 15));
            if (s[0]) div_m[7:0]  = w[7:0];
            if (s[1]) div_m[15:8] = w[15:8];
            reg_write(2'd2, s, w);
            reg_read(2'd2, "div_strobe", {16'd0, div_m});
        end

        // Single TX frame
        reg_write(2'd2, 4'h3, 32'd3);
        exp_q.delete();
        exp_q.push_back(8'h55);
        txlog.delete();
        log_en = 1'b1;
        reg_write(2'd0, 4'h1, 32'h55);
        reg_read(2'd1, "tx_busy_status", 32'h12);
        tick(45);
        reg_read(2'd1, "tx_done_status", 32'h02);
        log_en = 1'b0;
        check_tx(3, 2);

        // TX overflow: one byte leaves immediately, 16 are stored, the rest drop
        exp_q.delete();
        txlog.delete();
        log_en = 1'b1;
        for (int k = 0; k < 18; k++) begin
            b = 8'($urandom);
            if (k < TX_CAP + 1) exp_q.push_back(b);
            reg_write(2'd0, 4'h1, {24'd0, b});
        end
        reg_read(2'd1, "tx_full_status", 32'h11);
        tick(17 * 40 + 20);
        log_en = 1'b0;
        check_tx(3, 2);
        reg_read(2'd1, "tx_drain_status", 32'h02);

        // Loopback with the first frame 0xA5 at D=7, then random divisors
        loop_en = 1'b1;
        for (int it = 0; it < 4; it++) begin
            d = (it == 0) ? 7 : int'($urandom_range(2, 20));
            b = (it == 0) ? 8'hA5 : 8'($urandom);
            reg_write(2'd2, 4'h3, 32'(d));
            reg_write(2'd0, 4'h1, {24'd0, b});
            tick(10 * (d + 1) + 12);
            reg_read(2'd1, "lb_status", 32'h06);
            reg_read(2'd0, "lb_data", {1'b1, 23'd0, b});
            reg_read(2'd1, "lb_status_after", 32'h02);
        end
        loop_en = 1'b0;

        // RX overrun
        reg_write(2'd2, 4'h3, 32'd3);
        rxq.delete();
        for (int k = 0; k <= RX_CAP; k++) begin
            b = 8'($urandom);
            if (k < RX_CAP) rxq.push_back(b);
            send_rx(b, 1'b1, 3);
        end
        tick(10);
        reg_read(2'd1, "ovr_status", 32'h0E);
        foreach (rxq[k]) reg_read(2'd0, "ovr_data", {1'b1, 23'd0, rxq[k]});
        reg_read(2'd1, "ovr_drained", 32'h0A);
        reg_write(2'd1, 4'h1, 32'h08);
        reg_read(2'd1, "ovr_cleared", 32'h02);

        // Framing error
        send_rx(8'h3C, 1'b0, 3);
        tick(10);
        reg_read(2'd1, "fe_status", 32'h22);
        reg_write(2'd1, 4'h1, 32'h20);
        reg_read(2'd1, "fe_cleared", 32'h02);

        // One-cycle glitch, then a real byte
        rxd_drv = 1'b0;
        tick(1);
        rxd_drv = 1'b1;
        tick(20);
        reg_read(2'd1, "glitch_status", 32'h02);
        b = 8'($urandom);
        send_rx(b, 1'b1, 3);
        tick(10);
        reg_read(2'd0, "post_glitch_data", {1'b1, 23'd0, b});

        // Reset mid-frame
        reg_write(2'd2, 4'h3, 32'd7);
        for (int k = 0; k < 3; k++) reg_write(2'd0, 4'h1, 32'($urandom_range(0, 255)));
        n = 0;
        while (txd !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_txd_low", 32'(txd), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midframe_rst_txd", 32'(txd), 32'd1);
        check("midframe_rst_ready", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        txlog.delete();
        log_en = 1'b1;
        reg_read(2'd1, "post_rst_status", 32'h02);
        reg_read(2'd2, "post_rst_div", 32'd216);
        tick(100);
        log_en = 1'b0;
        zeros = 0;
        foreach (txlog[i]) if (txlog[i] !== 1'b1) zeros++;
        check("post_rst_no_frame", 32'(zeros), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
